icache_direct: RTL
==================

// Module: icache_direct
// PURPOSE
//   Direct-mapped, read-only instruction cache that services the core's
//   fetch-side interface (fetch PC/enable in, instruction/valid out).
//   It sits between the fetch stage and the memory system. On a miss it
//   refills one whole line through a request/beat fill port, then replays
//   the lookup. Tag and valid state live in flops; the data array is an
//   inferred RAM.
// PARAMETERS
//   ADDR_WIDTH   32  fetch and fill address width (bits)
//   DATA_WIDTH   32  instruction word and fill beat width (bits)
//   IC_LINES     16  number of lines; power of 2, >= 2
//   LINE_WORDS   4   words per line; power of 2, >= 2
// PORTS
//   clk           in   1                 core clock
//   n_rst         in   1                 async active-low reset
//   i_ic_en       in   1                 fetch request valid
//   i_ic_pc       in   ADDR_WIDTH        fetch address; bits[1:0] ignored
//   o_ic_insn     out  DATA_WIDTH        instruction word for the returned PC
//   o_ic_valid    out  1                 o_ic_insn valid; single-cycle pulse
//   i_ic_inval    in   1                 invalidate all lines
//   o_fill_req    out  1                 line fill request
//   o_fill_addr   out  ADDR_WIDTH        line-aligned fill address
//   i_fill_ack    in   1                 fill request accepted
//   i_fill_valid  in   1                 fill beat valid
//   i_fill_data   in   DATA_WIDTH        fill beat, ascending word order
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset n_rst is asynchronous and
//   active-low.
// - Values held in reset: FSM=IDLE; all line valid bits=0; o_ic_valid=0;
//   o_ic_insn=0; o_fill_req=0; o_fill_addr=0; beat count=0.
//   Reset asserted mid-refill abandons the refill and leaves the line
//   invalid.
// - Address split: offset = pc[log2(LINE_WORDS)+1:2];
//   index = next log2(IC_LINES) bits; tag = remaining upper bits.
// - IDLE (lookup):
//   - i_ic_en=1 and hit: o_ic_valid=1 with the word on the NEXT cycle
//     (1-cycle latency). Back-to-back hits give one word per cycle.
//   - i_ic_en=1 and miss: capture the pc and go to REQ. No o_ic_valid is
//     produced for that pc.
// - REQ:
//   - o_fill_req=1 and o_fill_addr=line address are held stable until
//     i_fill_ack=1 (req/ack handshake).
//   - Go to FILL on the cycle after ack. The req signals drop in that
//     same cycle.
// - FILL:
//   - Each i_fill_valid beat writes word[beat], then beat++.
//   - Beats with i_fill_valid=0 are stalls and are allowed.
//   - On beat LINE_WORDS-1: write the tag, set the line valid, go to IDLE.
//   - The requester is re-served by a normal lookup. That lookup hits
//     and returns valid on the following cycle.
// - Requester rules:
//   - The requester holds i_ic_en and i_ic_pc until o_ic_valid, but it may
//     change pc at any time (redirect). The response always matches the pc
//     sampled in the lookup cycle.
//   - A miss refill already in flight always completes, even if the pc
//     changed. The line is still installed.
// - Invalidation:
//   - i_ic_inval clears all valid bits in 1 cycle.
//   - If it arrives during FILL, the completing line is installed invalid.
//   - It overrides a same-cycle hit: o_ic_valid=0 next cycle.
// - Restrictions and boundaries:
//   - No new lookups are accepted while in REQ/FILL; o_ic_valid stays 0.
//   - A fill beat arriving in IDLE or REQ is ignored.
//   - Index/offset wrap naturally. Line LINE_WORDS-1 of index IC_LINES-1
//     needs no special case.
// TESTING
// - Reset, then fetch pc=0x0: miss; o_fill_req=1 with o_fill_addr=0x0;
//   ack; 4 beats 0x13,0x93,0x113,0x193; then o_ic_valid with insn=0x13.
// - After fill: pc 0x4,0x8,0xC on consecutive cycles return
//   0x93,0x113,0x193 one per cycle, 1-cycle latency, no fill_req.
// - Conflict: pc=0x100 (same index, IC_LINES=16) evicts line 0; refetch
//   0x0 misses again.
// - Hold i_fill_ack=0 for 5 cycles: o_fill_req and o_fill_addr stay
//   stable. Insert 2 idle beats mid-fill: data is still written in order.
// - Pulse i_ic_inval at the last fill beat: the next fetch of that line
//   misses. i_ic_inval in IDLE after hits: all lines miss.
// - Drop n_rst during beat 2 of a fill: outputs reset immediately; the
//   next fetch re-requests the same line.

Source files
------------

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 1-cycle hit, whole-line refill
// through a req/ack request phase followed by a beat-by-beat fill phase.
module icache_direct #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int IC_LINES   = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  i_ic_en,
   input  logic [ADDR_WIDTH-1:0] i_ic_pc,
   output logic [DATA_WIDTH-1:0] o_ic_insn,
   output logic                  o_ic_valid,
   input  logic                  i_ic_inval,
   output logic                  o_fill_req,
   output logic [ADDR_WIDTH-1:0] o_fill_addr,
   input  logic                  i_fill_ack,
   input  logic                  i_fill_valid,
   input  logic [DATA_WIDTH-1:0] i_fill_data
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(IC_LINES);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
   localparam int TAG_LSB = IDX_W + OFF_W + 2;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

   state_t                             state_q, state_d;
   logic [IC_LINES-1:0]                valid_q, valid_d;
   logic [IC_LINES-1:0][TAG_W-1:0]     tag_q, tag_d;
   logic [OFF_W-1:0]                   beat_q, beat_d;
   logic                               fill_req_q, fill_req_d;
   logic [ADDR_WIDTH-1:0]              fill_addr_q, fill_addr_d;
   logic                               ic_valid_q, ic_valid_d;
   logic [DATA_WIDTH-1:0]              ic_insn_q, ic_insn_d;
   logic                               inval_seen_q, inval_seen_d;

   logic [DATA_WIDTH-1:0] data_ram [IC_LINES*LINE_WORDS];
   logic                  ram_we;

   logic [OFF_W-1:0] pc_off;
   logic [IDX_W-1:0] pc_idx, fill_idx;
   logic [TAG_W-1:0] pc_tag, fill_tag;
   logic             hit;
   logic             unused_pc_lsb;

   assign pc_off   = i_ic_pc[OFF_W+1:2];
   assign pc_idx   = i_ic_pc[TAG_LSB-1:OFF_W+2];
   assign pc_tag   = i_ic_pc[ADDR_WIDTH-1:TAG_LSB];
   assign fill_idx = fill_addr_q[TAG_LSB-1:OFF_W+2];
   assign fill_tag = fill_addr_q[ADDR_WIDTH-1:TAG_LSB];
   assign hit      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   assign unused_pc_lsb = ^{i_ic_pc[1:0], fill_addr_q[TAG_LSB-1-IDX_W:0]};

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      beat_d       = beat_q;
      fill_req_d   = fill_req_q;
      fill_addr_d  = fill_addr_q;
      ic_valid_d   = 1'b0;
      ic_insn_d    = ic_insn_q;
      inval_seen_d = inval_seen_q;
      ram_we       = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_ic_en) begin
               if (hit) begin
                  // A same-cycle invalidate suppresses the hit response.
                  if (!i_ic_inval) begin
                     ic_valid_d = 1'b1;
                     ic_insn_d  = data_ram[{pc_idx, pc_off}];
                  end
               end else begin
                  state_d      = REQ;
                  fill_req_d   = 1'b1;
                  fill_addr_d  = {i_ic_pc[ADDR_WIDTH-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                  inval_seen_d = 1'b0;
               end
            end
         end
         REQ: begin
            if (i_fill_ack) begin
               state_d    = FILL;
               fill_req_d = 1'b0;
               beat_d     = '0;
            end
         end
         FILL: begin
            if (i_ic_inval) inval_seen_d = 1'b1;
            if (i_fill_valid) begin
               ram_we = 1'b1;
               beat_d = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  tag_d[fill_idx]   = fill_tag;
                  valid_d[fill_idx] = !inval_seen_q;
                  state_d           = IDLE;
                  beat_d            = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (i_ic_inval) valid_d = '0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         tag_q        <= '0;
         beat_q       <= '0;
         fill_req_q   <= 1'b0;
         fill_addr_q  <= '0;
         ic_valid_q   <= 1'b0;
         ic_insn_q    <= '0;
         inval_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         beat_q       <= beat_d;
         fill_req_q   <= fill_req_d;
         fill_addr_q  <= fill_addr_d;
         ic_valid_q   <= ic_valid_d;
         ic_insn_q    <= ic_insn_d;
         inval_seen_q <= inval_seen_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) data_ram[{fill_idx, beat_q}] <= i_fill_data;
   end

   assign o_ic_insn   = ic_insn_q;
   assign o_ic_valid  = ic_valid_q;
   assign o_fill_req  = fill_req_q;
   assign o_fill_addr = fill_addr_q;
endmodule
